// File: rtl/instr_fetch_mem.sv
// Byte-addressed instruction memory with a one-deep registered fetch response,
// plus a program port that can load the array at any time, including under reset.
module instr_fetch_mem #(
  parameter int                DATA_W      = 32,
  parameter int                DEPTH_BYTES = 256,
  parameter bit                BIG_ENDIAN  = 1'b1,
  parameter logic [DATA_W-1:0] NOP_WORD    = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [31:0]         req_pc,
  output logic                req_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_inscode,
  output logic [31:0]         rsp_pc,
  output logic                rsp_fault,
  input  logic                flush,
  input  logic                prog_we,
  input  logic [31:0]         prog_addr,
  input  logic [DATA_W-1:0]   prog_data,
  input  logic [DATA_W/8-1:0] prog_be,
  output logic [15:0]         fetch_count
);

  localparam int NB = DATA_W / 8;
  localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  logic [7:0] mem [DEPTH_BYTES];

  logic              rsp_valid_q,   rsp_valid_d;
  logic [DATA_W-1:0] rsp_inscode_q, rsp_inscode_d;
  logic [31:0]       rsp_pc_q,      rsp_pc_d;
  logic              rsp_fault_q,   rsp_fault_d;
  logic [15:0]       fetch_count_q, fetch_count_d;

  logic              req_ok;
  logic              prog_ok;
  logic              accept;
  logic              handoff;
  logic [DATA_W-1:0] rd_word;

  // Widened to 33 bits so an address near 2^32 cannot wrap into range.
  function automatic logic addr_ok(input logic [31:0] a);
    return ((a % 32'(NB)) == 32'd0) &&
           (({1'b0, a} + 33'(NB)) <= 33'(DEPTH_BYTES));
  endfunction

  assign req_ok  = addr_ok(req_pc);
  assign prog_ok = addr_ok(prog_addr);

  assign req_ready = rst && (!rsp_valid_q || rsp_ready) && !flush;
  assign accept    = req_valid && req_ready;
  assign handoff   = rsp_valid_q && rsp_ready && !flush;

  // Faulting fetches never touch the array; the word is forced to NOP_WORD.
  always_comb begin
    rd_word = NOP_WORD;
    if (req_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (BIG_ENDIAN) rd_word[DATA_W-1-8*i -: 8] = mem[AW'(req_pc + 32'(i))];
        else            rd_word[8*i +: 8]          = mem[AW'(req_pc + 32'(i))];
      end
    end
  end

  // Not reset, so code loaded during reset survives; reads sample pre-write data.
  always_ff @(posedge clk) begin
    if (prog_we && prog_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (prog_be[i]) begin
          if (BIG_ENDIAN) mem[AW'(prog_addr + 32'(i))] <= prog_data[DATA_W-1-8*i -: 8];
          else            mem[AW'(prog_addr + 32'(i))] <= prog_data[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rsp_valid_d   = rsp_valid_q;
    rsp_inscode_d = rsp_inscode_q;
    rsp_pc_d      = rsp_pc_q;
    rsp_fault_d   = rsp_fault_q;
    fetch_count_d = fetch_count_q + 16'(handoff);
    if (flush) begin
      rsp_valid_d = 1'b0;
    end else if (accept) begin
      rsp_valid_d   = 1'b1;
      rsp_inscode_d = rd_word;
      rsp_pc_d      = req_pc;
      rsp_fault_d   = !req_ok;
    end else if (handoff) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid_q   <= 1'b0;
      rsp_inscode_q <= '0;
      rsp_pc_q      <= '0;
      rsp_fault_q   <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      rsp_valid_q   <= rsp_valid_d;
      rsp_inscode_q <= rsp_inscode_d;
      rsp_pc_q      <= rsp_pc_d;
      rsp_fault_q   <= rsp_fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_inscode = rsp_inscode_q;
  assign rsp_pc      = rsp_pc_q;
  assign rsp_fault   = rsp_fault_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 Parameter DATA_W, 32, instruction width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH_BYTES, 256, byte capacity; SHALL be a multiple of DATA_W/8.
REQ-003 Parameter BIG_ENDIAN, 1, 1: lowest byte address is the MSB of the word; 0: it is the LSB.
REQ-004 Parameter NOP_WORD, 32'h0000_0000, word returned on a fault.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 req_valid  in  1  fetch request present.
REQ-008 req_pc  in  32  byte address of the fetch.
REQ-009 req_ready  out  1  request accepted on this clk edge when req_valid=1 and req_ready=1.
REQ-010 rsp_valid  out  1  response register holds a valid result.
REQ-011 rsp_ready  in  1  consumer takes the response when rsp_valid=1 and rsp_ready=1.
REQ-012 rsp_inscode  out  DATA_W  fetched instruction.
REQ-013 rsp_pc  out  32  req_pc of the returned fetch.
REQ-014 rsp_fault  out  1  fetch was misaligned or out of range.
REQ-015 flush  in  1  discard the held response (branch redirect).
REQ-016 prog_we  in  1  program-port word write strobe.
REQ-017 prog_addr  in  32  program-port byte address (word aligned).
REQ-018 prog_data  in  DATA_W  program-port write data.
REQ-019 prog_be  in  DATA_W/8  byte enables; bit i selects byte address prog_addr+i.
REQ-020 fetch_count  out  16  count of responses handed off.

Function
REQ-021 Storage SHALL be a DEPTH_BYTES x 8 array; reset SHALL NOT alter its contents.
REQ-022 req_ready SHALL equal (!rsp_valid || rsp_ready) && !flush.
REQ-023 On an accepted request, rsp_* SHALL be valid on the next clock edge: latency is exactly 1 cycle.
REQ-024 Word assembly SHALL concatenate bytes req_pc..req_pc+N-1 (N=DATA_W/8) in the order set by BIG_ENDIAN.
REQ-025 Fault if req_pc mod N != 0 or req_pc+N > DEPTH_BYTES; then rsp_fault=1, rsp_inscode=NOP_WORD, and no array read is used.
REQ-026 Backpressure: while rsp_valid=1 and rsp_ready=0, rsp_valid, rsp_inscode, rsp_pc and rsp_fault SHALL hold stable.
REQ-027 Back-to-back: with rsp_ready=1 continuously, one request SHALL be accepted every cycle with no bubbles.
REQ-028 Handoff with no new accept: rsp_valid SHALL clear on the next edge.
REQ-029 flush=1 SHALL clear rsp_valid on the next edge; no request is accepted that cycle; fetch_count is not incremented for the flushed response.
REQ-030 prog_we=1 with an aligned, in-range prog_addr SHALL write the enabled bytes on the clock edge; other writes SHALL be ignored.
REQ-031 The program port SHALL be independent of the request handshake and usable while fetches are in flight.
REQ-032 Read/write collision (same word, same edge) SHALL return the pre-write data (read-before-write).
REQ-033 fetch_count SHALL increment by 1 on each rsp_valid&&rsp_ready&&!flush and SHALL wrap 0xFFFF -> 0x0000.

Reset
REQ-034 rst=0 at a clock edge SHALL set rsp_valid=0, rsp_fault=0, rsp_inscode=0, rsp_pc=0, fetch_count=0.
REQ-035 While rst=0, req_ready SHALL be 0, and prog_we SHALL still write the array (boot loading under reset).
REQ-036 Reset mid-operation SHALL drop any held response; the first accept after rst rises SHALL behave as a fresh fetch.

Verification
REQ-037 Under reset, program 0x8C22000A at address 0 and 0xAC230005 at address 4 (BIG_ENDIAN=1); release reset; fetch PC 0, then PC 4 back-to-back -> rsp_inscode 0x8C22000A, then 0xAC230005 on consecutive cycles; fetch_count=2.
REQ-038 Fetch PC=2 -> rsp_fault=1, rsp_inscode=0x00000000, rsp_pc=2. Fetch PC=256 -> rsp_fault=1.
REQ-039 Fetch PC 0 with rsp_ready=0 for 3 cycles -> outputs stable and req_ready=0; rsp_ready=1 -> handoff occurs and fetch_count increments once.
REQ-040 Response pending, then flush=1 -> rsp_valid=0 next cycle, fetch_count unchanged, req_ready=0 during the flush cycle.
REQ-041 Same edge: fetch PC 8 and program 0x00A31025 at address 8 -> old word returned; refetch of PC 8 -> 0x00A31025. prog_be=4'b0001 at address 8 changes only byte address 8.
REQ-042 Assert rst=0 with a response held -> rsp_valid=0 and fetch_count=0 on the next edge; the array contents are retained.
